// File: rtl/sample_delay_line.sv
// Streaming delay line: circular sample buffer with a write pointer, a wrap-around read
// address, a priming guard against stale RAM contents, and a two-stage registered output.
module sample_delay_line #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] delay,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = {ADDR_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] fill_r;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic                  accept_s;

  logic                  s1_valid_r;
  logic                  s1_bypass_r;
  logic                  s1_primed_r;
  logic [DATA_WIDTH-1:0] s1_data_r;
  logic [DATA_WIDTH-1:0] mux_s;

  assign accept_s  = in_valid & ~rst;
  assign rd_addr_s = wr_ptr_r - delay;

  // Storage array: synchronous write, registered read, contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Write pointer wraps freely; fill saturates so long runs never re-arm the guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      fill_r   <= {ADDR_WIDTH{1'b0}};
    end else if (in_valid) begin
      wr_ptr_r <= wr_ptr_r + ADDR_ONE;
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + ADDR_ONE;
      end
    end
  end

  // Stage 1: select flags and bypass data travel alongside the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_bypass_r <= 1'b0;
      s1_primed_r <= 1'b0;
      s1_data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_bypass_r <= (delay == {ADDR_WIDTH{1'b0}});
        s1_primed_r <= (delay <= fill_r);
        s1_data_r   <= in_data;
      end
    end
  end

  // Zero delay must not use the RAM read, which would see the pre-write contents.
  always_comb begin
    mux_s = {DATA_WIDTH{1'b0}};
    if (s1_bypass_r) begin
      mux_s = s1_data_r;
    end else if (s1_primed_r) begin
      mux_s = rd_data_r;
    end else begin
      mux_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Stage 2: registered outputs; data holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data <= mux_s;
      end
    end
  end

endmodule

// File: tb/tb_sample_delay_line.sv
// Directed-vector bench for sample_delay_line: a hand-computed vector table plus
// multi-cycle sequences checked against a sample-history model.
module tb_sample_delay_line;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic [7:0]  delay;
  logic        out_valid;
  logic [11:0] out_data;

  sample_delay_line #(.ADDR_WIDTH(8), .DATA_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .delay(delay), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [11:0] d;
    logic [7:0]  dl;
    logic        ev;
    logic [11:0] ed;
  } vec_t;

  vec_t        tbl [16];
  logic [11:0] hist [4096];
  int          count;
  logic        pv;
  logic [11:0] pd;
  logic [11:0] held;
  int          n_checks;
  int          n_fail;
  int          n_in;
  int          n_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, then check outputs after the edge against the model.
  task automatic tick(input logic r, input logic v, input logic [11:0] d, input logic [7:0] dl);
    logic [11:0] e;
    rst = r; in_valid = v; in_data = d; delay = dl;
    @(posedge clk); #1;
    if (r) held = 12'h000;
    else if (pv) held = pd;
    chk("out_valid", {31'd0, out_valid}, {31'd0, (r ? 1'b0 : pv)});
    chk("out_data", {20'd0, out_data}, {20'd0, held});
    if (out_valid) n_out++;
    if (r) begin
      count = 0;
      pv = 1'b0;
    end else if (v) begin
      if (dl == 8'd0) e = d;
      else if (int'(dl) <= count) e = hist[count - int'(dl)];
      else e = 12'h000;
      hist[count] = d;
      count++;
      n_in++;
      pv = 1'b1;
      pd = e;
    end else begin
      pv = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; count = 0; pv = 1'b0; pd = 12'h000; held = 12'h000;
    n_in = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 12'h000; delay = 8'd0;

    // rst, v, d, delay, expected out_valid, expected out_data
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 8'd3, 1'b0, 12'h000};
    tbl[1]  = '{1'b0, 1'b1, 12'h001, 8'd3, 1'b0, 12'h000};
    tbl[2]  = '{1'b0, 1'b1, 12'h002, 8'd3, 1'b1, 12'h000};
    tbl[3]  = '{1'b0, 1'b1, 12'h003, 8'd3, 1'b1, 12'h000};
    tbl[4]  = '{1'b0, 1'b1, 12'h004, 8'd3, 1'b1, 12'h000};
    tbl[5]  = '{1'b0, 1'b1, 12'h005, 8'd3, 1'b1, 12'h001};
    tbl[6]  = '{1'b0, 1'b1, 12'h006, 8'd3, 1'b1, 12'h002};
    tbl[7]  = '{1'b0, 1'b0, 12'h000, 8'd3, 1'b1, 12'h003};
    tbl[8]  = '{1'b0, 1'b0, 12'h000, 8'd3, 1'b0, 12'h003};
    tbl[9]  = '{1'b0, 1'b1, 12'h5A5, 8'd0, 1'b0, 12'h003};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 8'd0, 1'b1, 12'h5A5};
    tbl[11] = '{1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 12'h5A5};
    tbl[12] = '{1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 12'h5A5};
    tbl[13] = '{1'b0, 1'b1, 12'h0F0, 8'd0, 1'b0, 12'h5A5};
    tbl[14] = '{1'b0, 1'b0, 12'h000, 8'd0, 1'b1, 12'h0F0};
    tbl[15] = '{1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 12'h0F0};

    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].dl);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_data", i), {20'd0, out_data}, {20'd0, tbl[i].ed});
    end

    // Maximum delay across two pointer wraps.
    tick(1'b1, 1'b0, 12'h000, 8'd255);
    for (int k = 0; k < 600; k++) tick(1'b0, 1'b1, 12'(k), 8'd255);
    tick(1'b0, 1'b0, 12'h000, 8'd255);
    chk("wrap_last", {20'd0, out_data}, 32'd344);
    tick(1'b0, 1'b0, 12'h000, 8'd255);

    // Delay increase beyond fill, then an immediate decrease.
    tick(1'b1, 1'b0, 12'h000, 8'd2);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 12'(12'h200 + k), 8'd2);
    for (int k = 10; k < 20; k++) tick(1'b0, 1'b1, 12'(12'h200 + k), 8'd8);
    for (int k = 20; k < 24; k++) tick(1'b0, 1'b1, 12'(12'h200 + k), 8'd1);
    tick(1'b0, 1'b0, 12'h000, 8'd1);
    chk("delay1_last", {20'd0, out_data}, 32'h216);
    tick(1'b0, 1'b0, 12'h000, 8'd1);

    // Reset mid-stream with two samples in flight; RAM still holds old data afterwards.
    tick(1'b1, 1'b0, 12'h000, 8'd4);
    for (int k = 0; k < 300; k++) tick(1'b0, 1'b1, 12'(12'h400 + k), 8'd4);
    tick(1'b0, 1'b1, 12'h7AA, 8'd4);
    tick(1'b0, 1'b1, 12'h7BB, 8'd4);
    tick(1'b1, 1'b1, 12'h7CC, 8'd4);
    chk("rst_drop0", {31'd0, out_valid}, 32'd0);
    tick(1'b0, 1'b0, 12'h000, 8'd4);
    chk("rst_drop1", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 12'(12'h300 + k), 8'd4);
    tick(1'b0, 1'b0, 12'h000, 8'd4);
    tick(1'b0, 1'b0, 12'h000, 8'd4);

    // Random strobes and delay changes; strobe counts must balance.
    tick(1'b1, 1'b0, 12'h000, 8'd0);
    n_in = 0; n_out = 0;
    begin
      logic [7:0] dl;
      dl = 8'd5;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0) dl = 8'($urandom_range(0, 255));
          else dl = 8'($urandom_range(0, 6));
        end
        tick(1'b0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), dl);
      end
    end
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 12'h000, 8'd0);
    chk("strobe_count", 32'(n_out), 32'(n_in));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
